// File: rtl/soc_test_monitor.sv
// Self-checking test monitor: follows retired PCs through a programmed checkpoint list,
// compares masked register values and reports PASS, FAIL or TIMEOUT.
module soc_test_monitor #(
   parameter int XLEN         = 32,
   parameter int NCHK         = 8,
   parameter int IDXW         = 3,
   parameter int CNTW         = 32,
   parameter bit STRICT_ORDER = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [IDXW:0]        chk_num,
   input  logic [NCHK*XLEN-1:0] chk_pc_flat,
   input  logic [NCHK*5-1:0]    chk_reg_flat,
   input  logic [NCHK*XLEN-1:0] chk_val_flat,
   input  logic [NCHK*XLEN-1:0] chk_mask_flat,
   input  logic [CNTW-1:0]      timeout_limit,
   input  logic                 retire_valid,
   input  logic [XLEN-1:0]      retire_pc,
   output logic [4:0]           rf_raddr,
   input  logic [XLEN-1:0]      rf_rdata,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic [1:0]           fail_code,
   output logic [IDXW-1:0]      fail_idx,
   output logic [CNTW-1:0]      cycle_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_VALUE   = 2'b01;
   localparam logic [1:0] FC_ORDER   = 2'b10;
   localparam logic [1:0] FC_TIMEOUT = 2'b11;

   // status flag encoding: {busy, done, pass, fail}
   localparam logic [3:0] FL_IDLE = 4'b0000;
   localparam logic [3:0] FL_RUN  = 4'b1000;
   localparam logic [3:0] FL_PASS = 4'b0110;
   localparam logic [3:0] FL_FAIL = 4'b0101;

   state_t            state_q;
   logic [3:0]        flags_q;
   logic [IDXW-1:0]   idx_q;
   logic [CNTW-1:0]   cnt_q;
   logic [CNTW-1:0]   cnt_d;
   logic [1:0]        fail_code_q;
   logic [IDXW-1:0]   fail_idx_q;

   logic [XLEN-1:0]   cur_pc_s;
   logic [XLEN-1:0]   cur_val_s;
   logic [XLEN-1:0]   cur_mask_s;
   logic [IDXW:0]     idx_ext_s;
   logic [IDXW:0]     j_s;
   logic              hit_s;
   logic              match_s;
   logic              last_s;
   logic              ooo_s;
   logic              timeout_s;

   assign rf_raddr = chk_reg_flat[idx_q*5 +: 5];

   // Decode the current checkpoint and the events that can end this cycle of the run.
   always_comb begin
      cur_pc_s   = chk_pc_flat[idx_q*XLEN +: XLEN];
      cur_val_s  = chk_val_flat[idx_q*XLEN +: XLEN];
      cur_mask_s = chk_mask_flat[idx_q*XLEN +: XLEN];
      idx_ext_s  = {1'b0, idx_q};
      hit_s      = retire_valid && (retire_pc == cur_pc_s);
      match_s    = ((rf_rdata ^ cur_val_s) & cur_mask_s) == {XLEN{1'b0}};
      last_s     = (idx_ext_s + (IDXW+1)'(1)) == chk_num;
      timeout_s  = (timeout_limit != {CNTW{1'b0}}) &&
                   (cnt_q == (timeout_limit - CNTW'(1)));
      cnt_d      = (&cnt_q) ? cnt_q : (cnt_q + CNTW'(1));
      ooo_s      = 1'b0;
      j_s        = {(IDXW+1){1'b0}};
      // A later active checkpoint retiring early means the program skipped one.
      for (int j = 0; j < NCHK; j++) begin
         j_s = (IDXW+1)'(j);
         if (STRICT_ORDER && retire_valid && !hit_s && (j_s > idx_ext_s) &&
             (j_s < chk_num) && (retire_pc == chk_pc_flat[j*XLEN +: XLEN])) begin
            ooo_s = 1'b1;
         end else begin
            ooo_s = ooo_s;
         end
      end
   end

   // Run-control state machine with registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         flags_q     <= FL_IDLE;
         idx_q       <= {IDXW{1'b0}};
         cnt_q       <= {CNTW{1'b0}};
         fail_code_q <= FC_NONE;
         fail_idx_q  <= {IDXW{1'b0}};
      end else begin
         case (state_q)
            S_IDLE, S_PASS, S_FAIL: begin
               if (start) begin
                  idx_q       <= {IDXW{1'b0}};
                  cnt_q       <= {CNTW{1'b0}};
                  fail_code_q <= FC_NONE;
                  fail_idx_q  <= {IDXW{1'b0}};
                  if (chk_num == {(IDXW+1){1'b0}}) begin
                     state_q <= S_PASS;
                     flags_q <= FL_PASS;
                  end else begin
                     state_q <= S_RUN;
                     flags_q <= FL_RUN;
                  end
               end
            end
            S_RUN: begin
               cnt_q <= cnt_d;
               if (hit_s) begin
                  if (!match_s) begin
                     state_q     <= S_FAIL;
                     flags_q     <= FL_FAIL;
                     fail_code_q <= FC_VALUE;
                     fail_idx_q  <= idx_q;
                  end else if (last_s) begin
                     state_q <= S_PASS;
                     flags_q <= FL_PASS;
                  end else begin
                     idx_q <= idx_q + IDXW'(1);
                  end
               end else if (ooo_s) begin
                  state_q     <= S_FAIL;
                  flags_q     <= FL_FAIL;
                  fail_code_q <= FC_ORDER;
                  fail_idx_q  <= idx_q;
               end else if (timeout_s) begin
                  state_q     <= S_FAIL;
                  flags_q     <= FL_FAIL;
                  fail_code_q <= FC_TIMEOUT;
                  fail_idx_q  <= idx_q;
               end
            end
            default: begin
               state_q <= S_IDLE;
               flags_q <= FL_IDLE;
            end
         endcase
      end
   end

   assign busy      = flags_q[3];
   assign done      = flags_q[2];
   assign pass      = flags_q[1];
   assign fail      = flags_q[0];
   assign fail_code = fail_code_q;
   assign fail_idx  = fail_idx_q;
   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_soc_test_monitor.sv
// Directed bench for soc_test_monitor: a scoreboard queue of expected final results is
// drained by a monitor whenever the strict-order instance reports done after a start.
module tb_soc_test_monitor;

   typedef struct packed {
      logic        pass;
      logic [1:0]  code;
      logic [2:0]  idx;
      logic [31:0] cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    chk_num = 4'd5;
   logic [255:0]  chk_pc_flat, chk_val_flat, chk_mask_flat;
   logic [39:0]   chk_reg_flat;
   logic [31:0]   timeout_limit = 32'd0;
   logic          retire_valid = 1'b0;
   logic [31:0]   retire_pc = 32'd0;
   logic [31:0]   rf_rdata = 32'd0;

   logic [4:0]    rf_raddr, ns_rf_raddr;
   logic          busy, done, pass, fail;
   logic          ns_busy, ns_done, ns_pass, ns_fail;
   logic [1:0]    fail_code, ns_fail_code;
   logic [2:0]    fail_idx, ns_fail_idx;
   logic [31:0]   cycle_cnt, ns_cycle_cnt;

   logic [31:0]   pc_a [8];
   logic [31:0]   val_a [8];
   logic [31:0]   mask_a [8];
   logic [4:0]    reg_a [8];

   exp_t          sb_q [$];
   int            n_tests = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   soc_test_monitor #(.STRICT_ORDER(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .chk_num(chk_num),
      .chk_pc_flat(chk_pc_flat), .chk_reg_flat(chk_reg_flat),
      .chk_val_flat(chk_val_flat), .chk_mask_flat(chk_mask_flat),
      .timeout_limit(timeout_limit), .retire_valid(retire_valid),
      .retire_pc(retire_pc), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .busy(busy), .done(done), .pass(pass), .fail(fail),
      .fail_code(fail_code), .fail_idx(fail_idx), .cycle_cnt(cycle_cnt));

   soc_test_monitor #(.STRICT_ORDER(1'b0)) dut_ns (
      .clk(clk), .reset(reset), .start(start), .chk_num(chk_num),
      .chk_pc_flat(chk_pc_flat), .chk_reg_flat(chk_reg_flat),
      .chk_val_flat(chk_val_flat), .chk_mask_flat(chk_mask_flat),
      .timeout_limit(timeout_limit), .retire_valid(retire_valid),
      .retire_pc(retire_pc), .rf_raddr(ns_rf_raddr), .rf_rdata(rf_rdata),
      .busy(ns_busy), .done(ns_done), .pass(ns_pass), .fail(ns_fail),
      .fail_code(ns_fail_code), .fail_idx(ns_fail_idx), .cycle_cnt(ns_cycle_cnt));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_default();
      for (int i = 0; i < 8; i++) begin
         pc_a[i]   = 32'h1c + 32'(i) * 32'h8;
         reg_a[i]  = 5'd5 + 5'(i);
         mask_a[i] = 32'hffff_ffff;
         val_a[i]  = 32'd0;
      end
      val_a[0] = 32'd1;
      val_a[1] = 32'd1;
      val_a[4] = 32'd1;
   endtask

   task automatic pack_cfg();
      for (int i = 0; i < 8; i++) begin
         chk_pc_flat[i*32 +: 32]   = pc_a[i];
         chk_val_flat[i*32 +: 32]  = val_a[i];
         chk_mask_flat[i*32 +: 32] = mask_a[i];
         chk_reg_flat[i*5 +: 5]    = reg_a[i];
      end
   endtask

   task automatic push(input logic p, input logic [1:0] c, input logic [2:0] i,
                       input logic [31:0] n);
      exp_t e;
      e.pass = p;
      e.code = c;
      e.idx  = i;
      e.cnt  = n;
      sb_q.push_back(e);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] data);
      retire_valid = 1'b1;
      retire_pc    = pc;
      rf_rdata     = data;
      tick();
      retire_valid = 1'b0;
      rf_rdata     = 32'd0;
   endtask

   // Monitor: a start arms it; the next cycle showing done pops and checks one result.
   initial begin : monitor
      logic st;
      logic armed;
      exp_t e;
      armed = 1'b0;
      forever begin
         @(posedge clk);
         st = start;
         @(negedge clk);
         if (st) armed = 1'b1;
         if (armed && done && !reset) begin
            armed = 1'b0;
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got code %0d with no expected result queued",
                        fail_code);
            end else begin
               e = sb_q.pop_front();
               check("result{pass,code,idx,cnt}",
                     64'({pass, fail_code, fail_idx, cycle_cnt}), 64'(e));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      load_default();
      pack_cfg();
      repeat (2) tick();
      check("reset_status", 64'({busy, done, pass, fail, fail_code, fail_idx, cycle_cnt}),
            64'd0);
      reset = 1'b0;
      tick();

      // 1: full passing run; 0x44 is entry 5, beyond chk_num, so it must be ignored
      push(1'b1, 2'b00, 3'd0, 32'd6);
      do_start();
      retire(32'h1c, 32'd1);
      check("raddr_idx1", 64'(rf_raddr), 64'd6);
      retire(32'h44, 32'd0);
      retire(32'h24, 32'd1);
      retire(32'h2c, 32'd0);
      retire(32'h34, 32'd0);
      check("busy_before_last", 64'({busy, done}), 64'b10);
      retire(32'h3c, 32'd1);
      tick();

      // 2: value mismatch at 0x24, then sticky
      push(1'b0, 2'b01, 3'd1, 32'd2);
      do_start();
      retire(32'h1c, 32'd1);
      retire(32'h24, 32'd0);
      retire(32'h2c, 32'd0);
      retire(32'h34, 32'd0);
      retire(32'h3c, 32'd1);
      check("mismatch_sticky", 64'({fail, fail_code, fail_idx, cycle_cnt}),
            64'({1'b1, 2'b01, 3'd1, 32'd2}));

      // 3: 0x2c before 0x24; strict instance fails, relaxed instance continues to PASS
      push(1'b0, 2'b10, 3'd1, 32'd2);
      do_start();
      retire(32'h1c, 32'd1);
      retire(32'h2c, 32'd0);
      check("relaxed_still_run", 64'({ns_busy, ns_done}), 64'b10);
      retire(32'h24, 32'd1);
      retire(32'h2c, 32'd0);
      retire(32'h34, 32'd0);
      retire(32'h3c, 32'd1);
      check("relaxed_pass", 64'({ns_pass, ns_fail_code, ns_cycle_cnt}),
            64'({1'b1, 2'b00, 32'd6}));
      check("order_sticky", 64'({fail, fail_code, fail_idx, cycle_cnt}),
            64'({1'b1, 2'b10, 3'd1, 32'd2}));

      // 4a: timeout with no hits
      timeout_limit = 32'h115;
      push(1'b0, 2'b11, 3'd0, 32'h115);
      do_start();
      repeat (32'h115) tick();
      tick();
      // 4b: final checkpoint passing in the timeout cycle wins
      chk_num = 4'd1;
      push(1'b1, 2'b00, 3'd0, 32'h115);
      do_start();
      repeat (32'h114) tick();
      retire(32'h1c, 32'd1);
      tick();
      timeout_limit = 32'd0;

      // 5a: empty list passes at once
      chk_num = 4'd0;
      push(1'b1, 2'b00, 3'd0, 32'd0);
      do_start();
      tick();
      // 5b: mask 0x1, expected 0x3, read 0x1 -> passes
      chk_num   = 4'd1;
      mask_a[0] = 32'h1;
      val_a[0]  = 32'h3;
      pack_cfg();
      push(1'b1, 2'b00, 3'd0, 32'd1);
      do_start();
      retire(32'h1c, 32'h1);
      tick();

      // 6: reset mid-run at idx 3, then a clean rerun
      load_default();
      pack_cfg();
      chk_num = 4'd5;
      do_start();
      retire(32'h1c, 32'd1);
      retire(32'h24, 32'd1);
      retire(32'h2c, 32'd0);
      check("raddr_idx3", 64'(rf_raddr), 64'd8);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_status",
            64'({busy, done, pass, fail, fail_code, fail_idx, cycle_cnt}), 64'd0);
      check("raddr_after_reset", 64'(rf_raddr), 64'd5);
      #1;
      reset = 1'b0;
      tick();
      push(1'b1, 2'b00, 3'd0, 32'd5);
      do_start();
      retire(32'h1c, 32'd1);
      retire(32'h24, 32'd1);
      retire(32'h2c, 32'd0);
      retire(32'h34, 32'd0);
      retire(32'h3c, 32'd1);
      repeat (3) tick();

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/soc_test_monitor.md
Name: soc_test_monitor

Overview:
- Parametrised self-checking monitor for core-level directed tests.
- Watches the retire stream and a register-file read port.
- Compares register values against a programmed list of PC checkpoints.
- Flags PASS, FAIL (value mismatch or out-of-order checkpoint) or TIMEOUT.
- Generalises single-program hard-wired PC/register checks into a reusable block: N checkpoints, masked compares, selectable strict ordering, programmable cycle budget. Sits beside the core in the SoC test harness; its status outputs drive the bench's stop logic.

Parameters:
XLEN, 32, width of PC and register data
NCHK, 8, maximum number of checkpoints
IDXW, 3, checkpoint index width, must be >= clog2(NCHK)
CNTW, 32, cycle counter / timeout width
STRICT_ORDER, 1, 1 = retiring a later checkpoint's PC before the current one is a FAIL

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begins a run
chk_num  in  IDXW+1  number of active checkpoints, 0..NCHK
chk_pc_flat  in  NCHK*XLEN  checkpoint PCs, entry i at [i*XLEN +: XLEN]
chk_reg_flat  in  NCHK*5  register index checked at entry i
chk_val_flat  in  NCHK*XLEN  expected value for entry i
chk_mask_flat  in  NCHK*XLEN  compare mask for entry i (1 = bit compared)
timeout_limit  in  CNTW  cycle budget; 0 = no timeout
retire_valid  in  1  an instruction retires this cycle
retire_pc  in  XLEN  PC of the retiring instruction
rf_raddr  out  5  register read address, combinational = chk_reg[idx]
rf_rdata  in  XLEN  register value read at rf_raddr, same cycle
busy  out  1  state == RUN
done  out  1  state is PASS or FAIL
pass  out  1  state == PASS
fail  out  1  state == FAIL
fail_code  out  2  00 none, 01 value mismatch, 10 out of order, 11 timeout
fail_idx  out  IDXW  checkpoint index at failure
cycle_cnt  out  CNTW  cycles spent in RUN

Behaviour:
- States IDLE, RUN, PASS, FAIL.
- Reset (asynchronous, any state):
  - state = IDLE; all outputs 0.
  - idx = 0, cycle_cnt = 0.
- start in IDLE, PASS or FAIL:
  - Clears idx, cycle_cnt, fail_code and fail_idx.
  - Next state RUN, or PASS if chk_num == 0.
- start in RUN is ignored.
- Configuration inputs are held stable during RUN; they are not latched.
- RUN, every cycle:
  - cycle_cnt increments, saturating at all-ones.
  - hit = retire_valid && retire_pc == chk_pc[idx].
  - On hit, compare (rf_rdata & mask[idx]) against (chk_val[idx] & mask[idx]).
    - Equal and idx == chk_num-1: PASS.
    - Equal otherwise: idx increments.
    - Not equal: FAIL, code 01, fail_idx = idx.
  - Out of order (STRICT_ORDER=1 only):
    - Condition: no hit, retire_valid, and retire_pc equals chk_pc[j] for some idx < j < chk_num.
    - Result: FAIL, code 10, fail_idx = idx.
  - Timeout: timeout_limit != 0 and cycle_cnt == timeout_limit-1 with no terminal event this cycle. Result: FAIL, code 11, fail_idx = idx.
- Priority within one cycle: hit evaluation, then out-of-order, then timeout. A passing final checkpoint in the timeout cycle yields PASS.
- Duplicate PCs in the list are legal and are consumed sequentially, one per retire.
- Latency: status outputs are registered and change the cycle after the deciding retire.
- PASS and FAIL are sticky until reset or start. cycle_cnt freezes in terminal states.
- Entries at or above chk_num are never compared.

Test Plan:
1. chk_num=5; PCs 0x1c,0x24,0x2c,0x34,0x3c; reg 5; values 1,1,0,0,1; full masks; retires with matching rf_rdata -> PASS one cycle after the 0x3c retire, fail_code 00.
2. Same list, rf_rdata=0 at PC 0x24 -> FAIL, code 01, fail_idx 1; outputs unchanged afterwards until start.
3. STRICT_ORDER=1, retire 0x2c before 0x24 (idx 1) -> FAIL code 10, fail_idx 1. Same stimulus with STRICT_ORDER=0 -> stays RUN.
4. timeout_limit=0x115, no checkpoint hits -> FAIL code 11 with cycle_cnt = 0x115. Final checkpoint passing in that same cycle -> PASS instead.
5. chk_num=0, start -> PASS next cycle. Mask 0x1 with value 0x3 expected vs rf_rdata 0x1 -> compare passes.
6. reset asserted mid-RUN at idx 3 -> immediate IDLE, all outputs 0. A new start re-runs from idx 0.
